// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external ALU: IDLE grants, EXEC drives the ALU, RESP holds the result.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; the default build is fixed priority (requester 0 wins).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_sl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   id_q;
    logic   grant0;
    logic   grant1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie, grant the requester that was not granted last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
    end
`else
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`endif

    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    // ALU operand registers double as the latched request; they are cleared whenever EXEC is left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            id_q      <= 1'b0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_sl    <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_sign  <= 1'b0;
            ops_done  <= 16'd0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_in1 <= grant1 ? req1_a  : req0_a;
                        alu_in2 <= grant1 ? req1_b  : req0_b;
                        alu_sl  <= grant1 ? req1_op : req0_op;
                        id_q    <= grant1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_q  <= grant1;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_zero  <= alu_zero;
                    rsp_sign  <= alu_sign;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    alu_in1   <= '0;
                    alu_in2   <= '0;
                    alu_sl    <= 3'd0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic [W-1:0]  alu_in1, alu_in2, alu_out;
    logic [2:0]    alu_sl;
    logic          alu_zero, alu_sign;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_sign;
    logic [W-1:0]  rsp_data;
    logic [15:0]   ops_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sl(alu_sl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
        .ops_done(ops_done)
    );

    // Shared ALU model; undefined select codes return 0.
    always_comb begin
        case (alu_sl)
            3'd0:    alu_out = alu_in1 + alu_in2;
            3'd1:    alu_out = alu_in1 - alu_in2;
            3'd2:    alu_out = alu_in1 & alu_in2;
            3'd3:    alu_out = alu_in1 | alu_in2;
            3'd4:    alu_out = alu_in1 ^ alu_in2;
            3'd5:    alu_out = W'(($signed(alu_in1) < $signed(alu_in2)) ? 1 : 0);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
        alu_sign = alu_out[W-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts just after a negedge in IDLE and returns at the negedge after the response transfer.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] exp_data,
                         input logic exp_zero, input logic exp_sign, input logic [15:0] exp_ops);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        check("grant_ready0", 32'(req0_ready), 32'(!id));
        check("grant_ready1", 32'(req1_ready), 32'(id));
        @(negedge clk);
        check("exec_readys", 32'({req0_ready, req1_ready}), 32'd0);
        check("exec_in1", alu_in1, a);
        check("exec_in2", alu_in2, b);
        check("exec_sl", 32'(alu_sl), 32'(op));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_readys", 32'({req0_ready, req1_ready}), 32'd0);
        check("resp_id", 32'(rsp_id), 32'(id));
        check("resp_data", rsp_data, exp_data);
        check("resp_flags", 32'({rsp_zero, rsp_sign}), 32'({exp_zero, exp_sign}));
        check("resp_alu_idle", 32'(alu_sl), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("done_valid", 32'(rsp_valid), 32'd0);
        check("done_ops", 32'(ops_done), 32'(exp_ops));
    endtask

    logic        ids [4];
    int          nrsp;
    logic [31:0] held;

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = 3'd0;
        req1_a = '0; req1_b = '0; req1_op = 3'd0;

        // Reset state, with a request pending to show ready stays low.
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ops", 32'(ops_done), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_zero, rsp_sign}), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_alu", alu_in1 | alu_in2 | 32'(alu_sl), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 1'b0, 16'd1);
        do_op(1'b1, 32'd3, 32'd3, 3'd1, 32'd0, 1'b1, 1'b0, 16'd2);
        do_op(1'b1, 32'd1, 32'd2, 3'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd3);
        do_op(1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 32'h00F0_1200, 1'b0, 1'b0, 16'd4);
        do_op(1'b1, 32'hA5A5_0000, 32'h0F0F_00FF, 3'd3, 32'hAFAF_00FF, 1'b0, 1'b1, 16'd5);
        do_op(1'b0, 32'h1234_5678, 32'h1234_5678, 3'd4, 32'd0, 1'b1, 1'b0, 16'd6);
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5, 32'd1, 1'b0, 1'b0, 16'd7);
        do_op(1'b0, 32'd9, 32'd4, 3'd6, 32'd0, 1'b1, 1'b0, 16'd8);

        // Back-pressure: response held while rsp_ready is low, readys stay low despite a new request.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd23; req1_op = 3'd0;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        held = rsp_data;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd0;
        check("stall_data", held, 32'd123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_hold", rsp_data, held);
            check("stall_readys", 32'({req0_ready, req1_ready}), 32'd0);
            check("stall_ops", 32'(ops_done), 32'd8);
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ops", 32'(ops_done), 32'd9);
        check("stall_release_valid", 32'(rsp_valid), 32'd0);

        // Reset while in EXEC discards the operation.
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        check("rst_exec_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_ops", 32'(ops_done), 32'd0);
        check("rst_exec_alu", alu_in1, 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Both requesters valid continuously: four responses, order depends on the arbitration build.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = 3'd0;
        nrsp = 0;
        for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            @(negedge clk);
            check("both_one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (rsp_valid) begin
                ids[nrsp] = rsp_id;
                check("both_data", rsp_data, rsp_id ? 32'd4 : 32'd2);
                nrsp++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("both_count", 32'(nrsp), 32'd4);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        check("both_seq", 32'({ids[0], ids[1], ids[2], ids[3]}), 32'b0101);
`else
        check("both_seq", 32'({ids[0], ids[1], ids[2], ids[3]}), 32'b0000);
`endif
        @(negedge clk);
        check("both_ops", 32'(ops_done), 32'd4);

        // Counter wrap from 0xFFFF.
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        #1;
        check("wrap_preload", 32'(ops_done), 32'h0000_FFFF);
        do_op(1'b0, 32'd8, 32'd3, 3'd1, 32'd5, 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width and match the shared ALU port width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  SHALL indicate requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  SHALL indicate the operation is accepted this cycle; transfer = valid & ready.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH  SHALL carry the operands.
REQ-007 req0_op / req1_op  input  3  SHALL carry the ALU select code (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101).
REQ-008 alu_in1, alu_in2  output  WIDTH; alu_sl  output  3  SHALL drive the shared ALU.
REQ-009 alu_out  input  WIDTH; alu_zero, alu_sign  input  1  SHALL return the ALU result and flags.
REQ-010 rsp_valid  output  1; rsp_ready  input  1  SHALL form the response handshake; transfer = rsp_valid & rsp_ready.
REQ-011 rsp_id  output  1; rsp_data  output  WIDTH; rsp_zero, rsp_sign  output  1  SHALL carry requester id, result, flags.
REQ-012 ops_done  output  16  SHALL count completed responses.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, assert exactly one reqN_ready (combinationally) for the granted requester, latch its a/b/op and id, go to EXEC; else stay.
REQ-015 reqN_ready SHALL be 0 in EXEC and RESP; at most one ready is high in any cycle.
REQ-016 EXEC: drive latched operands/op onto alu_in1/alu_in2/alu_sl, register alu_out/alu_zero/alu_sign at cycle end, go to RESP.
REQ-017 RESP: hold rsp_valid=1 with stable rsp_id/rsp_data/rsp_zero/rsp_sign until rsp_ready=1, then go to IDLE.
REQ-018 Latency: acceptance in cycle N SHALL give rsp_valid=1 in cycle N+2; next acceptance no earlier than the cycle after the response transfer.
REQ-019 alu_in1/alu_in2/alu_sl SHALL be 0 outside EXEC.
REQ-020 Undefined op codes (110, 111) SHALL be forwarded unchanged; result is whatever the ALU returns (0, zero=1).
REQ-021 ops_done SHALL increment by 1 on each response transfer and wrap 0xFFFF -> 0x0000.
REQ-022 A requester dropping valid while not granted SHALL not be served; no request is queued internally.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_sign=0, ops_done=0, last-grant pointer=1.
REQ-024 Reset during EXEC or RESP SHALL discard the in-flight operation with no response and no ops_done increment.
REQ-025 reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-026 Macro ALU_ARB_ROUND_ROBIN_EN defined: when both valid in IDLE, grant the requester not equal to the last-grant pointer; pointer updates on every grant.
REQ-027 ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins on simultaneous valid; pointer logic absent.
REQ-028 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-029 After reset, req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready cycle N, rsp_valid N+2, rsp_id=0, rsp_data=12, zero=0, sign=0, ops_done=1.
REQ-030 req1 SUB a=3 b=3 -> rsp_data=0, rsp_zero=1; SUB a=1 b=2 -> rsp_data=0xFFFFFFFF, rsp_sign=1.
REQ-031 Both valid continuously, 4 ops, with macro -> rsp_id sequence 0,1,0,1; without macro -> 0,0,0,0.
REQ-032 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, both readys 0, ops_done unchanged until transfer.
REQ-033 rst_n=0 asserted in EXEC -> next cycle IDLE, rsp_valid=0, ops_done=0, no response emitted.
REQ-034 Preload 0xFFFF completions (or force counter) then one more -> ops_done=0x0000.
